// File: rtl/ub_pkg.sv
// ---------------------------------------------------------------------------
// ub_pkg
// Shared definitions for the unified-buffer read sequencer slice:
//   - default SRAM address width, SRAM word width and output buffer depth
//   - the sequencer state enum (IDLE / RUN / DRAIN)
// ---------------------------------------------------------------------------
package ub_pkg;

  localparam int UB_ADDRESSSIZE = 10;
  localparam int UB_WORDSIZE    = 160;
  localparam int UB_FIFO_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ub_state_t;

endpackage

// File: rtl/ub_sync_fifo.sv
// ---------------------------------------------------------------------------
// ub_sync_fifo
// Single-clock FIFO used as the output buffer of the read sequencer.
// DEPTH must be a power of two (pointers wrap naturally).
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - synchronous active-low reset (pointers and count only)
//   push       - write push_data at the tail (ignored when full)
//   push_data  - data to write
//   pop        - drop the head entry (ignored when empty)
//   pop_data   - current head entry (valid while !empty)
//   count      - number of stored entries, 0..DEPTH
//   full       - count == DEPTH
//   empty      - count == 0
// ---------------------------------------------------------------------------
module ub_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify requests with the occupancy flags so a stray request can never
  // corrupt the pointers. A simultaneous push and pop leaves count alone.
  always_comb begin
    full     = (count == CW'(DEPTH));
    empty    = (count == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    pop_data = mem[rd_ptr];
  end

  // Pointer and occupancy bookkeeping; reset empties the buffer but leaves the
  // storage array untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, deliberately without reset so it maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/ub_read_sequencer.sv
// ---------------------------------------------------------------------------
// ub_read_sequencer
// Streams a burst of consecutive SRAM words out on a valid/ready interface.
// A start pulse in IDLE latches base_addr and length; the sequencer then
// issues one SRAM read per cycle while the output buffer has room (counting
// the read already in flight), wraps the address at 2^ADDRESSSIZE, and flags
// the final word with out_last. While idle, the host may write the SRAM.
//
// Ports:
//   clk, rst_n                      - clock and synchronous active-low reset
//   start, base_addr, length        - burst request (length 0 just pulses done)
//   host_we, host_addr, host_wdata  - host SRAM write, accepted while idle
//   host_wready                     - high while idle
//   sram_write_enable, sram_address,
//   sram_data_in, sram_data_out     - SRAM port, read data 1 cycle after addr
//   out_valid, out_ready,
//   out_data, out_last              - downstream stream
//   busy                            - high while a burst is in progress
//   done                            - one-cycle pulse when a burst finishes
// ---------------------------------------------------------------------------
module ub_read_sequencer
  import ub_pkg::*;
#(
  parameter int ADDRESSSIZE = UB_ADDRESSSIZE,
  parameter int WORDSIZE    = UB_WORDSIZE,
  parameter int FIFO_DEPTH  = UB_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic [ADDRESSSIZE:0]   length,
  input  logic                   host_we,
  input  logic [ADDRESSSIZE-1:0] host_addr,
  input  logic [WORDSIZE-1:0]    host_wdata,
  output logic                   host_wready,
  output logic                   sram_write_enable,
  output logic [ADDRESSSIZE-1:0] sram_address,
  output logic [WORDSIZE-1:0]    sram_data_in,
  input  logic [WORDSIZE-1:0]    sram_data_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WORDSIZE-1:0]    out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ub_state_t              state_q;
  ub_state_t              state_d;
  logic [ADDRESSSIZE-1:0] addr_q;
  logic [ADDRESSSIZE:0]   remaining_q;
  logic                   inflight_q;
  logic                   inflight_last_q;
  logic                   done_q;

  logic                   accept_start;
  logic                   host_write;
  logic                   issue;
  logic                   final_issue;
  logic                   pop;
  logic                   last_pop;

  logic [WORDSIZE:0]      fifo_wdata;
  logic [WORDSIZE:0]      fifo_rdata;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;

  // Each buffer entry carries the SRAM word plus a last-word flag, so
  // out_last travels with its data and stays stable under back-pressure.
  assign fifo_wdata = {inflight_last_q, sram_data_out};

  ub_sync_fifo #(
    .WIDTH (WORDSIZE + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (fifo_wdata),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // State register for the IDLE/RUN/DRAIN sequencer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode. A read is only issued when the words
  // already buffered plus the one still coming back from SRAM leave a free
  // slot, so every returning word is guaranteed a place in the buffer.
  // The host write shares the SRAM port and is only honoured in IDLE; when
  // it coincides with start both happen, since no read is issued in IDLE.
  always_comb begin
    state_d           = state_q;
    host_wready       = (state_q == IDLE);
    busy              = (state_q != IDLE);
    host_write        = host_we && (state_q == IDLE);
    accept_start      = start && (state_q == IDLE);
    issue             = 1'b0;
    final_issue       = 1'b0;
    sram_write_enable = host_write;
    sram_address      = host_write ? host_addr : addr_q;
    sram_data_in      = host_wdata;
    out_valid         = !fifo_empty;
    out_data          = fifo_rdata[WORDSIZE-1:0];
    out_last          = !fifo_empty && fifo_rdata[WORDSIZE];
    pop               = out_valid && out_ready;
    last_pop          = pop && out_last;
    done              = done_q;

    if (state_q == RUN) begin
      issue = (remaining_q != '0) && !fifo_full &&
              ((int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH);
      final_issue = issue && (remaining_q == (ADDRESSSIZE+1)'(1));
    end

    case (state_q)
      IDLE: begin
        if (accept_start && (length != '0)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (final_issue) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Burst datapath: address and remaining-word counters, the one-deep
  // in-flight tracker for the SRAM read latency, and the delayed done pulse
  // used for zero-length requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= final_issue;
      done_q          <= accept_start && (length == '0);
      if (accept_start && (length != '0)) begin
        addr_q      <= base_addr;
        remaining_q <= length;
      end else if (issue) begin
        addr_q      <= addr_q + ADDRESSSIZE'(1);
        remaining_q <= remaining_q - (ADDRESSSIZE+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_ub_read_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ub_read_sequencer
// Table-driven plus randomized bench for ub_read_sequencer. A behavioural
// SRAM sits on the SRAM port; a separate reference copy of the memory is
// updated only by the bench's own host writes, and each burst is expected to
// return ref_mem[(base+i) mod 1024] with out_last on the final word.
// ---------------------------------------------------------------------------
module tb_ub_read_sequencer;

  localparam int AW     = 10;
  localparam int WW     = 160;
  localparam int DEPTH  = 4;
  localparam int NWORDS = 1 << AW;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    bit            rand_ready;
    bit            wr_with_start;
    bit            we_during;
    int            exp_first_k;
    int            exp_done_k;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [WW-1:0] host_wdata = '0;
  logic          host_wready;
  logic          sram_write_enable;
  logic [AW-1:0] sram_address;
  logic [WW-1:0] sram_data_in;
  logic [WW-1:0] sram_data_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  int assert_count = 0;
  int fail_count   = 0;

  logic [WW-1:0] sram_mem [NWORDS];
  logic [WW-1:0] ref_mem  [NWORDS];
  vec_t          vecs     [8];

  always #5 clk = ~clk;

  ub_read_sequencer #(
    .ADDRESSSIZE (AW),
    .WORDSIZE    (WW),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .base_addr         (base_addr),
    .length            (length),
    .host_we           (host_we),
    .host_addr         (host_addr),
    .host_wdata        (host_wdata),
    .host_wready       (host_wready),
    .sram_write_enable (sram_write_enable),
    .sram_address      (sram_address),
    .sram_data_in      (sram_data_in),
    .sram_data_out     (sram_data_out),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_last          (out_last),
    .busy              (busy),
    .done              (done)
  );

  // Behavioural SRAM: synchronous write, read data registered one cycle later.
  always @(posedge clk) begin
    if (sram_write_enable) begin
      sram_mem[sram_address] <= sram_data_in;
    end
    sram_data_out <= sram_mem[sram_address];
  end

  function automatic logic [WW-1:0] randWord();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string name, input logic [WW-1:0] actual,
                             input logic [WW-1:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_out_valid"},   WW'(out_valid),         WW'(0));
    checkOutput({tag, "_out_last"},    WW'(out_last),          WW'(0));
    checkOutput({tag, "_done"},        WW'(done),              WW'(0));
    checkOutput({tag, "_busy"},        WW'(busy),              WW'(0));
    checkOutput({tag, "_sram_we"},     WW'(sram_write_enable), WW'(0));
    checkOutput({tag, "_sram_addr"},   WW'(sram_address),      WW'(0));
    checkOutput({tag, "_host_wready"}, WW'(host_wready),       WW'(1));
  endtask

  // Runs one burst described by v, monitoring the stream every cycle, then
  // compares what came out against the reference memory and timing rules.
  task automatic applyStimulus(input vec_t v, input string tag);
    logic [WW-1:0] got_data [$];
    logic          got_last [$];
    logic [WW-1:0] prev_data;
    logic          prev_last;
    logic [AW-1:0] wa;
    int  first_k = -1;
    int  done_k = -1;
    int  done_cnt = 0;
    int  stall_err = 0;
    int  we_err = 0;
    int  max_cnt = 0;
    int  k = 0;
    int  exp_addr;
    bit  done_on_last = 1'b0;
    bit  prev_stall = 1'b0;
    bit  timed_out = 1'b0;

    prev_data = '0;
    prev_last = 1'b0;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = v.base;
    length    = v.len;
    out_ready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (v.wr_with_start) begin
      wa          = v.base + AW'(1);
      host_we     = 1'b1;
      host_addr   = wa;
      host_wdata  = randWord();
      ref_mem[wa] = host_wdata;
    end

    forever begin
      @(negedge clk);
      if (out_valid && first_k < 0) first_k = k;
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        stall_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      if (host_we && k > 0 && (host_wready || sram_write_enable)) we_err++;
      if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
      if (done) begin
        done_cnt++;
        if (done_k < 0) begin
          done_k = k;
          done_on_last = (v.len == 0) || (out_valid && out_ready && out_last);
        end
      end
      if (done_k >= 0 && k >= done_k + 3) break;
      if (k >= 300) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
      k++;
      start     = 1'b0;
      out_ready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v.we_during && done_k < 0) begin
        wa         = v.base + AW'(v.len) - AW'(1);
        host_we    = 1'b1;
        host_addr  = wa;
        host_wdata = ~ref_mem[wa];
      end else begin
        host_we = 1'b0;
      end
    end
    host_we = 1'b0;

    checkOutput({tag, "_timeout"},     WW'(timed_out),      WW'(0));
    checkOutput({tag, "_first_valid"}, WW'(first_k),        WW'(v.exp_first_k));
    checkOutput({tag, "_word_count"},  WW'(got_data.size()), WW'(v.len));
    for (int i = 0; i < got_data.size() && i < int'(v.len); i++) begin
      exp_addr = (int'(v.base) + i) % NWORDS;
      checkOutput($sformatf("%s_data%0d", tag, i), got_data[i], ref_mem[exp_addr]);
      checkOutput($sformatf("%s_last%0d", tag, i), WW'(got_last[i]),
                  WW'(i == int'(v.len) - 1));
    end
    checkOutput({tag, "_done_count"}, WW'(done_cnt), WW'(1));
    if (v.exp_done_k >= 0)
      checkOutput({tag, "_done_cycle"}, WW'(done_k), WW'(v.exp_done_k));
    checkOutput({tag, "_done_with_last"}, WW'(done_on_last), WW'(1));
    checkOutput({tag, "_stall_stable"},   WW'(stall_err),    WW'(0));
    checkOutput({tag, "_fifo_bound"},     WW'(max_cnt <= DEPTH), WW'(1));
    if (v.we_during)
      checkOutput({tag, "_host_blocked"}, WW'(we_err), WW'(0));
    checkOutput({tag, "_idle_busy"},   WW'(busy),        WW'(0));
    checkOutput({tag, "_idle_wready"}, WW'(host_wready), WW'(1));
  endtask

  // Main sequence: reset, table vectors, mid-burst reset, random bursts.
  initial begin
    vec_t v;
    int   pops;
    int   guard;
    int   bad_done;
    int   bad_valid;

    for (int a = 0; a < NWORDS; a++) begin
      ref_mem[a]  = randWord();
      sram_mem[a] = ref_mem[a];
    end

    vecs[0] = '{10'd5,    11'd4, 1'b0, 1'b0, 1'b0, 3, 6};
    vecs[1] = '{10'd1022, 11'd4, 1'b0, 1'b0, 1'b0, 3, 6};
    vecs[2] = '{10'd37,   11'd8, 1'b1, 1'b0, 1'b0, 3, -1};
    vecs[3] = '{10'd0,    11'd0, 1'b0, 1'b0, 1'b0, -1, 1};
    vecs[4] = '{10'd200,  11'd6, 1'b0, 1'b0, 1'b1, 3, 8};
    vecs[5] = '{10'd300,  11'd5, 1'b0, 1'b1, 1'b0, 3, 7};
    vecs[6] = '{10'd1020, 11'd9, 1'b1, 1'b0, 1'b0, 3, -1};
    vecs[7] = '{10'd512,  11'd1, 1'b0, 1'b0, 1'b0, 3, 3};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkResetOutputs("reset");

    for (int n = 0; n < 8; n++) begin
      applyStimulus(vecs[n], $sformatf("vec%0d", n));
    end

    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = 10'd100;
    length    = 11'd8;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pops  = 0;
    guard = 0;
    while (pops < 2 && guard < 50) begin
      @(negedge clk);
      if (out_valid && out_ready) pops++;
      guard++;
    end
    checkOutput("midreset_two_pops", WW'(pops), WW'(2));
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkResetOutputs("midreset");
    bad_done  = 0;
    bad_valid = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) bad_done++;
      if (out_valid) bad_valid++;
    end
    checkOutput("midreset_no_done",  WW'(bad_done),  WW'(0));
    checkOutput("midreset_no_valid", WW'(bad_valid), WW'(0));
    applyStimulus('{10'd700, 11'd5, 1'b0, 1'b0, 1'b0, 3, 7}, "after_reset");

    for (int r = 0; r < 6; r++) begin
      v.base          = AW'($urandom_range(0, NWORDS - 1));
      v.len           = (AW+1)'($urandom_range(1, 12));
      v.rand_ready    = 1'b1;
      v.wr_with_start = 1'b0;
      v.we_during     = 1'b0;
      v.exp_first_k   = 3;
      v.exp_done_k    = -1;
      applyStimulus(v, $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/ub_read_sequencer.md
UB_READ_SEQUENCER -- requirements
Module: ub_read_sequencer

Interface
REQ-001 SHALL have parameter ADDRESSSIZE, default 10, meaning the SRAM address width.
REQ-002 SHALL have parameter WORDSIZE, default 160, meaning the SRAM word width (8*20).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the output buffer entries (power of 2, at least 2).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset: synchronous and active-low.
REQ-006 SHALL have port start, input, 1, a one-cycle request to begin a burst read.
REQ-007 SHALL have port base_addr, input, ADDRESSSIZE, the first word address, sampled with start.
REQ-008 SHALL have port length, input, ADDRESSSIZE+1, the word count (0..2^ADDRESSSIZE), sampled with start.
REQ-009 SHALL have ports host_we (input, 1), host_addr (input, ADDRESSSIZE), host_wdata (input, WORDSIZE) and host_wready (output, 1), the host write port.
REQ-010 SHALL have ports sram_write_enable (output, 1), sram_address (output, ADDRESSSIZE), sram_data_in (output, WORDSIZE) and sram_data_out (input, WORDSIZE), the SRAM port; SRAM read data arrives 1 cycle after the address while write_enable=0.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, WORDSIZE) and out_last (output, 1), the downstream stream.
REQ-012 SHALL have ports busy (output, 1) and done (output, 1), the status outputs; done is a one-cycle pulse.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DRAIN.
REQ-014 SHALL accept start only in IDLE: length>0 goes to RUN, length=0 raises done in the next cycle and stays in IDLE; start is ignored outside IDLE.
REQ-015 SHALL in RUN issue one read per cycle (sram_write_enable=0, sram_address=current address) only when fifo_count + inflight < FIFO_DEPTH; inflight is 1 if a read was issued in the previous cycle.
REQ-016 SHALL increment the address per issued read modulo 2^ADDRESSSIZE (1023 wraps to 0).
REQ-017 SHALL push sram_data_out into the FIFO in the cycle after each issued read, and only then.
REQ-018 SHALL move RUN to DRAIN after the length-th read is issued.
REQ-019 SHALL move DRAIN to IDLE when the last word is popped (out_valid and out_ready and out_last), and pulse done in that same cycle.
REQ-020 SHALL present the FIFO head on out_data with out_valid = FIFO non-empty; a pop occurs on out_valid and out_ready.
REQ-021 SHALL keep out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-022 SHALL assert out_last only on the length-th word of the burst.
REQ-023 SHALL on a FIFO push and pop in the same cycle keep the count unchanged and lose no data.
REQ-024 SHALL, with out_ready held at 1, raise the first out_valid 3 cycles after the start cycle and then sustain 1 word/cycle.
REQ-025 SHALL assert busy when the state is not IDLE.
REQ-026 SHALL drive host_wready = (state==IDLE) and pass the host write to the SRAM port when host_we and host_wready are both high.
REQ-027 SHALL give the host write priority if host_we and start occur in the same IDLE cycle: the write executes and the burst starts next cycle with no read issued that cycle.
REQ-028 SHALL otherwise drive sram_write_enable=0; sram_data_in is don't-care.

Reset
REQ-029 SHALL on rst_n=0 at a rising edge set: state IDLE, FIFO empty, inflight 0, address 0, remaining count 0, out_valid 0, out_last 0, done 0, busy 0, sram_write_enable 0, sram_address 0.
REQ-030 SHALL treat reset during RUN or DRAIN as aborting the burst: buffered data is discarded and no done pulse is produced.
REQ-031 SHALL leave out_data and the FIFO storage unreset.

Structure
REQ-032 SHALL place the ADDRESSSIZE and WORDSIZE defaults, FIFO_DEPTH and the state enum in shared package ub_pkg.
REQ-033 SHALL implement the output buffer as sub-module ub_sync_fifo (push/pop/count/full/empty, same clk/rst_n).

Verification
REQ-034 SHALL cover: base 5, length 4, out_ready=1 -> reads at 5,6,7,8; out_valid first seen 3 cycles after start; 4 consecutive words; out_last on word 4; done in the same cycle.
REQ-035 SHALL cover: base 1022, length 4 -> addresses 1022,1023,0,1.
REQ-036 SHALL cover: length 8, out_ready toggling 1-0-0-1 randomly -> in-order data, no loss or duplicate, fifo_count never above 4, out_data stable while stalled.
REQ-037 SHALL cover: length 0 -> done one cycle later, no SRAM read issued, out_valid never 1.
REQ-038 SHALL cover: host_we during RUN -> host_wready=0 and no SRAM write; host_we and start together in IDLE -> write lands and the burst still completes correctly.
REQ-039 SHALL cover: rst_n=0 mid-burst after 2 words popped -> next cycle all outputs at reset values, no done; a new start then streams correctly.
